apb_timer_s: RTL and testbench
==============================

Name: apb_timer_s

Overview:
- APB slave timer: 16-bit down-counter with 8-bit prescaler, one-shot or auto-reload, and a sticky expiry flag driving an interrupt line.
- Sits directly downstream of the APB interconnect on the TIMR0 select line.
- Consumes the interconnect's shared M_PADDR/M_PWRITE/M_PENABLE/M_PWDATA and its own M_PSELx bit.
- Returns PRDATA/PREADY into the interconnect's per-slave response vectors.

Parameters:
- BUS_WIDTH, 16, APB address width.
- DATA_WIDTH, 16, APB data width; the counter and LOAD register are this width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- S_PADDR  input  BUS_WIDTH  APB address; only bits [1:0] are decoded.
- S_PWRITE  input  1  1 = write, 0 = read.
- S_PSELx  input  1  slave select from the interconnect address decoder.
- S_PENABLE  input  1  APB access-phase strobe.
- S_PWDATA  input  DATA_WIDTH  write data.
- S_PRDATA  output  DATA_WIDTH  read data.
- S_PREADY  output  1  transfer complete.
- int_out  output  1  interrupt, level, active-high.

Behaviour:
- Reset, async on reset=1: CTRL, LOAD, COUNT, STATUS and the prescale counter all go to 0; S_PREADY=0, S_PRDATA=0, int_out=0. Reset asserted mid-transfer aborts the transfer; no write is committed.
- Register map, PADDR[1:0]:
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IRQ_EN, bits[15:8] PSC. Other bits read 0.
  - 1 LOAD: reload value.
  - 2 COUNT: read = current count; write = load count directly.
  - 3 STATUS: bit0 EXP. Write 1 to clear; writing 0 has no effect.
- APB handshake:
  - Zero wait states: S_PREADY = S_PSELx & S_PENABLE (combinational).
  - A write commits on the rising edge that ends the access phase (PSELx & PENABLE & PWRITE).
  - S_PRDATA is combinational from the addressed register while S_PSELx=1, and 0 otherwise.
  - Setup phase (PSELx=1, PENABLE=0) has no side effects. A back-to-back transfer is accepted.
- Prescaler:
  - 8-bit counter psc_cnt.
  - While EN=1: if psc_cnt==PSC, assert tick for one cycle and set psc_cnt=0; else psc_cnt+1.
  - While EN=0: psc_cnt held at 0.
  - Any CTRL write clears psc_cnt.
  - A tick therefore occurs every PSC+1 cycles; PSC=0 gives a tick every cycle.
- Counter, on tick:
  - If COUNT!=0: COUNT-1.
  - If COUNT==0 (expiry): EXP<=1. With RELOAD=1, COUNT<=LOAD. With RELOAD=0, COUNT stays 0 and EN<=0 (one-shot).
  - Period is LOAD+1 ticks. LOAD=0 with RELOAD=1 expires on every tick.
- int_out: registered, int_out <= EXP & IRQ_EN. It asserts 1 cycle after EXP sets, and deasserts 1 cycle after EXP clears or IRQ_EN drops.
- Simultaneous events, same cycle:
  - COUNT write vs tick: the write wins; no decrement or reload that cycle.
  - CTRL write vs one-shot auto-clear of EN: the written EN value wins. The expiry and EXP set still occur.
  - STATUS clear vs expiry: the set wins, EXP=1.
  - LOAD write vs reload: the reload uses the old LOAD; the new value takes effect next period.
- Arithmetic: unsigned, DATA_WIDTH bits. The decrement never wraps below 0; 0 triggers expiry handling instead.

Test Plan:
- Reset values: assert reset async mid-cycle -> all reads 0, int_out=0, S_PREADY=0; then APB read of each address 0-3 -> 0x0000 with S_PREADY=1 only in the access phase.
- Auto-reload: write LOAD=3, then CTRL=0x0007 (PSC=0, EN, RELOAD, IRQ_EN) -> COUNT reads 3,2,1,0 on successive cycles, EXP sets every 4 cycles, int_out rises 1 cycle after the first expiry; write STATUS=1 -> int_out falls 1 cycle later and re-rises at the next expiry.
- Prescaler + one-shot: LOAD=2, CTRL=0x0301 (PSC=3, EN) -> COUNT decrements every 4 cycles, EXP=1 after 12 cycles, CTRL reads 0x0300 (EN cleared), COUNT stays 0, int_out stays 0 (IRQ_EN=0).
- Collisions: COUNT write 0x0010 on a tick cycle -> COUNT reads 0x0010 next; STATUS clear on an expiry cycle -> EXP reads 1; LOAD write on a reload cycle -> reload uses the old LOAD, the new LOAD applies on the following expiry.
- APB protocol: setup phase held 3 cycles with PWRITE=1 -> no register change; back-to-back write then read of LOAD=0xBEEF -> read returns 0xBEEF; PSELx=0 -> S_PRDATA=0 and S_PREADY=0.

Source files
------------

// File: rtl/apb_timer_s.sv
// APB slave timer: 16-bit down-counter behind an 8-bit prescaler.
// Supports one-shot or auto-reload, with a sticky expiry flag that drives a level interrupt.
module apb_timer_s #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic                  int_out
);

  typedef struct packed {
    logic [7:0] psc;
    logic       irq_en;
    logic       reload;
    logic       en;
  } ctrl_t;

  ctrl_t                 ctrl;
  logic [DATA_WIDTH-1:0] load_q;
  logic [DATA_WIDTH-1:0] count;
  logic                  exp_q;
  logic [7:0]            psc_cnt;
  logic [DATA_WIDTH-1:0] rdata;

  logic wr, wr_ctrl, wr_load, wr_count, wr_status;
  logic tick, expire;
  logic unused_addr;

  assign unused_addr = ^S_PADDR[BUS_WIDTH-1:2];

  assign wr        = S_PSELx & S_PENABLE & S_PWRITE;
  assign wr_ctrl   = wr && (S_PADDR[1:0] == 2'd0);
  assign wr_load   = wr && (S_PADDR[1:0] == 2'd1);
  assign wr_count  = wr && (S_PADDR[1:0] == 2'd2);
  assign wr_status = wr && (S_PADDR[1:0] == 2'd3);

  assign tick   = ctrl.en && (psc_cnt == ctrl.psc);
  assign expire = tick && (count == '0);

  // Reset gates the bus outputs so an in-flight transfer looks aborted.
  assign S_PREADY = S_PSELx & S_PENABLE & ~reset;

  always_comb begin
    rdata = '0;
    case (S_PADDR[1:0])
      2'd0: begin
        rdata[15:8] = ctrl.psc;
        rdata[2]    = ctrl.irq_en;
        rdata[1]    = ctrl.reload;
        rdata[0]    = ctrl.en;
      end
      2'd1:    rdata = load_q;
      2'd2:    rdata = count;
      default: rdata[0] = exp_q;
    endcase
  end

  assign S_PRDATA = (S_PSELx && !reset) ? rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt <= '0;
    end else if (wr_ctrl || !ctrl.en || tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 8'd1;
    end
  end

  // Bus writes are placed after the timer updates so the written value wins on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl    <= '0;
      load_q  <= '0;
      count   <= '0;
      exp_q   <= 1'b0;
      int_out <= 1'b0;
    end else begin
      int_out <= exp_q & ctrl.irq_en;
      if (expire) begin
        if (ctrl.reload) count <= load_q;
        else             ctrl.en <= 1'b0;
      end else if (tick) begin
        count <= count - 1'b1;
      end
      if (wr_status && S_PWDATA[0]) exp_q <= 1'b0;
      if (expire) exp_q <= 1'b1;
      if (wr_ctrl) begin
        ctrl.psc    <= S_PWDATA[15:8];
        ctrl.irq_en <= S_PWDATA[2];
        ctrl.reload <= S_PWDATA[1];
        ctrl.en     <= S_PWDATA[0];
      end
      if (wr_load)  load_q <= S_PWDATA;
      if (wr_count) count  <= S_PWDATA;
    end
  end

endmodule

// File: tb/tb_apb_timer_s.sv
// Bench for apb_timer_s: directed scenarios plus random register traffic.
// Each step is checked against a cycle-level behavioural model of the timer.
module tb_apb_timer_s;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, int_out;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic        m_en, m_rl, m_irq, m_exp, m_int;
  logic [7:0]  m_psc, m_since;
  logic [15:0] m_load, m_count;
  logic [15:0] rd;

  apb_timer_s #(.BUS_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready), .int_out(int_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_en, m_rl, m_irq, m_exp, m_int} = '0;
    m_psc = '0; m_since = '0; m_load = '0; m_count = '0;
  endtask

  function automatic logic [15:0] mread(input logic [1:0] a);
    case (a)
      2'd0:    return {m_psc, 5'b0, m_irq, m_rl, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {15'b0, m_exp};
    endcase
  endfunction

  // One clock edge of the timer, applied to the model using the bus as currently driven.
  task automatic model_edge();
    logic wr, tick, expire;
    logic [1:0] a;
    wr     = psel && penable && pwrite;
    a      = paddr[1:0];
    tick   = m_en && (m_since == m_psc);
    expire = tick && (m_count == 16'd0);
    m_int  = m_exp && m_irq;
    if ((wr && a == 2'd0) || !m_en || tick) m_since = 8'd0;
    else                                    m_since = m_since + 8'd1;
    if (expire) begin
      m_exp = 1'b1;
      if (m_rl) m_count = m_load;
      else      m_en = 1'b0;
    end else if (tick) begin
      m_count = m_count - 16'd1;
    end
    if (wr) begin
      case (a)
        2'd0: begin m_psc = pwdata[15:8]; m_irq = pwdata[2]; m_rl = pwdata[1]; m_en = pwdata[0]; end
        2'd1: m_load = pwdata;
        2'd2: m_count = pwdata;
        default: if (pwdata[0] && !expire) m_exp = 1'b0;
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("int_out", {15'b0, int_out}, {15'b0, m_int});
  endtask

  // Setup-phase peek: side-effect free, PRDATA is live, PREADY must stay low.
  task automatic peek(input logic [1:0] a);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {14'b0, a};
    #1;
    chk($sformatf("peek%0d", a), prdata, mread(a));
    chk("pready_setup", {15'b0, pready}, 16'd0);
    psel = 1'b0;
  endtask

  task automatic peek_all();
    for (int a = 0; a < 4; a++) peek(2'(a));
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {14'b0, a}; pwdata = d;
    step();
    penable = 1'b1;
    #1;
    chk("pready_wr", {15'b0, pready}, 16'd1);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {14'b0, a};
    #1;
    chk("pready_rd_setup", {15'b0, pready}, 16'd0);
    step();
    penable = 1'b1;
    #1;
    d = prdata;
    chk("pready_rd", {15'b0, pready}, 16'd1);
    chk($sformatf("read%0d", a), d, mread(a));
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset asserted in the middle of a LOAD write access phase
    psel = 1'b1; pwrite = 1'b1; paddr = 16'd1; pwdata = 16'h5555;
    step();
    penable = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_pready", {15'b0, pready}, 16'd0);
    chk("rst_prdata", prdata, 16'd0);
    chk("rst_int", {15'b0, int_out}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; psel = 0; penable = 0; pwrite = 0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      apb_read(2'(a), rd);
      chk("rst_val", rd, 16'd0);
    end

    // auto-reload, period 4, interrupt enabled
    apb_write(2'd1, 16'd3);
    apb_write(2'd0, 16'h0007);
    repeat (10) begin peek(2'd2); peek(2'd3); step(); end
    apb_write(2'd3, 16'h0001);
    repeat (6) begin peek(2'd2); peek(2'd3); step(); end

    // prescaler + one-shot
    apb_write(2'd0, 16'h0000);
    apb_write(2'd3, 16'h0001);
    apb_write(2'd1, 16'd2);
    apb_write(2'd2, 16'd2);
    apb_write(2'd0, 16'h0301);
    repeat (16) begin peek(2'd2); step(); end
    peek_all();
    apb_read(2'd0, rd);
    chk("oneshot_ctrl", rd, 16'h0300);
    apb_read(2'd2, rd);
    chk("oneshot_count", rd, 16'd0);
    apb_read(2'd3, rd);
    chk("oneshot_exp", rd, 16'd1);
    chk("oneshot_int", {15'b0, int_out}, 16'd0);

    // collisions with PSC=0 so every cycle ticks
    apb_write(2'd1, 16'd100);
    apb_write(2'd0, 16'h0003);
    apb_write(2'd2, 16'h0010);
    peek(2'd2);
    chk("coll_count", prdata, 16'h0010);
    step();
    peek(2'd2);
    chk("coll_count_dec", prdata, 16'h000F);
    apb_write(2'd1, 16'd0);
    apb_write(2'd2, 16'd0);
    step();
    apb_write(2'd3, 16'h0001);
    peek(2'd3);
    chk("coll_status", prdata, 16'd1);
    apb_write(2'd1, 16'd5);
    peek(2'd2);
    chk("coll_load_old", prdata, 16'd0);
    step();
    peek(2'd2);
    chk("coll_load_new", prdata, 16'd5);
    apb_write(2'd0, 16'h0000);

    // protocol: long setup phase with PWRITE high changes nothing
    apb_write(2'd1, 16'h1111);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 16'd1; pwdata = 16'h2222;
    repeat (3) step();
    psel = 1'b0; pwrite = 1'b0;
    peek(2'd1);
    chk("setup_no_write", prdata, 16'h1111);
    // back-to-back write then read
    apb_write(2'd1, 16'hBEEF);
    apb_read(2'd1, rd);
    chk("b2b_read", rd, 16'hBEEF);
    psel = 1'b0; penable = 1'b1; paddr = 16'd1;
    #1;
    chk("nosel_prdata", prdata, 16'd0);
    chk("nosel_pready", {15'b0, pready}, 16'd0);
    penable = 1'b0;

    // random register traffic with small periods so expiries are frequent
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: apb_write(2'd0, {8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)});
        1: apb_write(2'd1, 16'($urandom_range(0, 7)));
        2: apb_write(2'd2, 16'($urandom_range(0, 7)));
        3: apb_write(2'd3, 16'($urandom_range(0, 1)));
        default: begin peek_all(); step(); end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
